// File: rtl/it_block_ctrl.sv
// -----------------------------------------------------------------------------
// it_block_ctrl
//   Tracks the Thumb IT (If-Then) execution state. Holds ITSTATE, advances it as
//   instructions inside an IT block retire, and handles exception entry/return
//   and direct EPSR writes. Derives the per-instruction condition pass, the
//   remaining block length and change/error pulses.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   it_load         IT instruction retired (it_firstcond, it_mask)
//   inst_valid      non-IT instruction retired (advances the block)
//   apsr_nzcv       current flags {N,Z,C,V}
//   exc_entry       exception entry, abandons the block
//   exc_return      exception return, restores ret_it
//   msr_we          direct ITSTATE write of msr_it
//   itstate         current ITSTATE[7:0]
//   in_it           inside an IT block
//   cond_pass       current instruction's condition passes
//   last_in_it      current instruction is the last of the block
//   it_rem          instructions remaining in the block (0..4)
//   it_we           pulse: itstate changed on the preceding edge
//   it_err          pulse: IT loaded while already inside a block
// -----------------------------------------------------------------------------
module it_block_ctrl (
   input  logic       clk,
   input  logic       rst,
   input  logic       it_load,
   input  logic [3:0] it_firstcond,
   input  logic [3:0] it_mask,
   input  logic       inst_valid,
   input  logic [3:0] apsr_nzcv,
   input  logic       exc_entry,
   input  logic       exc_return,
   input  logic [7:0] ret_it,
   input  logic       msr_we,
   input  logic [7:0] msr_it,
   output logic [7:0] itstate,
   output logic       in_it,
   output logic       cond_pass,
   output logic       last_in_it,
   output logic [2:0] it_rem,
   output logic       it_we,
   output logic       it_err
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_LAST   = 2'd2
   } state_e;

   state_e     state_q, state_d;
   logic [7:0] itstate_q, itstate_d;
   logic       it_we_q, it_we_d;
   logic       it_err_q, it_err_d;

   // ARM condition evaluation: cond[3:1] selects the base test, cond[0]
   // inverts it, except for the 111x "always" encodings.
   function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] nzcv);
      logic n, z, c, v, r;
      n = nzcv[3];
      z = nzcv[2];
      c = nzcv[1];
      v = nzcv[0];
      case (cond[3:1])
         3'b000:  r = z;
         3'b001:  r = c;
         3'b010:  r = n;
         3'b011:  r = v;
         3'b100:  r = c & ~z;
         3'b101:  r = (n == v);
         3'b110:  r = ~z & (n == v);
         default: r = 1'b1;
      endcase
      if (cond[0] && (cond[3:1] != 3'b111)) begin
         r = ~r;
      end
      return r;
   endfunction

   function automatic state_e state_of(input logic [7:0] its);
      state_e s;
      if (its[3:0] == 4'b0000) begin
         s = ST_IDLE;
      end else if (its[3:0] == 4'b1000) begin
         s = ST_LAST;
      end else begin
         s = ST_ACTIVE;
      end
      return s;
   endfunction

   always_comb begin
      itstate_d = itstate_q;
      it_err_d  = 1'b0;
      // Single update per edge in strict priority order. An IT with an
      // empty mask is a no-op but still claims its priority slot.
      if (exc_entry) begin
         itstate_d = 8'h00;
      end else if (exc_return) begin
         itstate_d = ret_it;
      end else if (msr_we) begin
         itstate_d = msr_it;
      end else if (it_load) begin
         if (it_mask != 4'b0000) begin
            itstate_d = {it_firstcond, it_mask};
            it_err_d  = in_it;
         end
      end else if (inst_valid && in_it) begin
         if (itstate_q[2:0] == 3'b000) begin
            itstate_d = 8'h00;
         end else begin
            itstate_d = {itstate_q[7:5], itstate_q[3:0], 1'b0};
         end
      end
      it_we_d = (itstate_d != itstate_q);
      state_d = state_of(itstate_d);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         itstate_q <= 8'h00;
         state_q   <= ST_IDLE;
         it_we_q   <= 1'b0;
         it_err_q  <= 1'b0;
      end else begin
         itstate_q <= itstate_d;
         state_q   <= state_d;
         it_we_q   <= it_we_d;
         it_err_q  <= it_err_d;
      end
   end

   always_comb begin
      casez (itstate_q[3:0])
         4'b0000: it_rem = 3'd0;
         4'b1000: it_rem = 3'd1;
         4'b?100: it_rem = 3'd2;
         4'b??10: it_rem = 3'd3;
         default: it_rem = 3'd4;
      endcase
   end

   assign itstate    = itstate_q;
   assign in_it      = (state_q != ST_IDLE);
   assign last_in_it = (state_q == ST_LAST);
   assign cond_pass  = ~in_it | cond_eval(itstate_q[7:4], apsr_nzcv);
   assign it_we      = it_we_q;
   assign it_err     = it_err_q;

endmodule

// File: tb/tb_it_block_ctrl.sv
// -----------------------------------------------------------------------------
// tb_it_block_ctrl
//   Directed bench for it_block_ctrl with a behavioural model compared every
//   cycle, plus literal expectations at key points of each scenario.
// -----------------------------------------------------------------------------
module tb_it_block_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       it_load;
   logic [3:0] it_firstcond;
   logic [3:0] it_mask;
   logic       inst_valid;
   logic [3:0] apsr_nzcv;
   logic       exc_entry;
   logic       exc_return;
   logic [7:0] ret_it;
   logic       msr_we;
   logic [7:0] msr_it;
   logic [7:0] itstate;
   logic       in_it;
   logic       cond_pass;
   logic       last_in_it;
   logic [2:0] it_rem;
   logic       it_we;
   logic       it_err;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   // model state
   logic [7:0] m_its = 8'h00;
   logic       m_we  = 1'b0;
   logic       m_err = 1'b0;

   it_block_ctrl dut (
      .clk(clk), .rst(rst), .it_load(it_load), .it_firstcond(it_firstcond),
      .it_mask(it_mask), .inst_valid(inst_valid), .apsr_nzcv(apsr_nzcv),
      .exc_entry(exc_entry), .exc_return(exc_return), .ret_it(ret_it),
      .msr_we(msr_we), .msr_it(msr_it), .itstate(itstate), .in_it(in_it),
      .cond_pass(cond_pass), .last_in_it(last_in_it), .it_rem(it_rem),
      .it_we(it_we), .it_err(it_err)
   );

   always #5 clk = ~clk;

   // Condition table written out per encoding.
   function automatic bit cond_tbl(input logic [3:0] c, input logic [3:0] f);
      bit n, z, cy, v;
      n = f[3]; z = f[2]; cy = f[1]; v = f[0];
      case (c)
         4'd0:  return z;
         4'd1:  return !z;
         4'd2:  return cy;
         4'd3:  return !cy;
         4'd4:  return n;
         4'd5:  return !n;
         4'd6:  return v;
         4'd7:  return !v;
         4'd8:  return cy && !z;
         4'd9:  return !cy || z;
         4'd10: return n == v;
         4'd11: return n != v;
         4'd12: return !z && (n == v);
         4'd13: return z || (n != v);
         default: return 1'b1;
      endcase
   endfunction

   // Remaining instructions = 4 minus the index of the lowest set mask bit.
   function automatic int rem_of(input logic [7:0] s);
      for (int k = 0; k < 4; k++) begin
         if (s[k]) return 4 - k;
      end
      return 0;
   endfunction

   always @(posedge clk) begin
      logic [7:0] nx;
      nx = m_its;
      if (rst) begin
         m_its <= 8'h00;
         m_we  <= 1'b0;
         m_err <= 1'b0;
      end else begin
         m_err <= 1'b0;
         if (exc_entry)       nx = 8'h00;
         else if (exc_return) nx = ret_it;
         else if (msr_we)     nx = msr_it;
         else if (it_load) begin
            if (it_mask != 4'd0) begin
               nx = {it_firstcond, it_mask};
               m_err <= (rem_of(m_its) != 0);
            end
         end else if (inst_valid && rem_of(m_its) != 0) begin
            if (rem_of(m_its) == 1) nx = 8'h00;
            else nx = (m_its & 8'hE0) | ((m_its << 1) & 8'h1F);
         end
         m_we  <= (nx != m_its);
         m_its <= nx;
      end
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         int  r;
         bit  cp;
         r  = rem_of(m_its);
         cp = (r == 0) ? 1'b1 : cond_tbl(m_its[7:4], apsr_nzcv);
         check("m_itstate", itstate, m_its);
         check("m_in_it", in_it, r != 0);
         check("m_it_rem", it_rem, r);
         check("m_last", last_in_it, r == 1);
         check("m_cond_pass", cond_pass, cp);
         check("m_it_we", it_we, m_we);
         check("m_it_err", it_err, m_err);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      rst = 0; it_load = 0; inst_valid = 0; exc_entry = 0;
      exc_return = 0; msr_we = 0;
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   task automatic load(input logic [3:0] fc, input logic [3:0] mk);
      it_load = 1; it_firstcond = fc; it_mask = mk;
      tick();
   endtask

   initial begin
      rst = 1; it_load = 0; it_firstcond = 0; it_mask = 0; inst_valid = 0;
      apsr_nzcv = 4'b0000; exc_entry = 0; exc_return = 0; ret_it = 0;
      msr_we = 0; msr_it = 0;
      @(posedge clk); #1;
      rst = 1;
      tick();
      chk_en = 1'b1;
      settle();
      check("rst_itstate", itstate, 8'h00);
      check("rst_in_it", in_it, 0);
      check("rst_cond_pass", cond_pass, 1);
      check("rst_it_rem", it_rem, 0);
      check("rst_we", it_we, 0);

      // ITTE EQ with Z=1
      apsr_nzcv = 4'b0100;
      load(4'b0000, 4'b0110);
      settle();
      check("itte_load", itstate, 8'h06);
      check("itte_rem3", it_rem, 3);
      check("itte_we", it_we, 1);
      check("itte_cp1", cond_pass, 1);
      inst_valid = 1; tick(); settle();
      check("itte_adv1", itstate, 8'h0C);
      check("itte_rem2", it_rem, 2);
      check("itte_cp2", cond_pass, 1);
      inst_valid = 1; tick(); settle();
      check("itte_adv2", itstate, 8'h18);
      check("itte_last", last_in_it, 1);
      check("itte_cp3", cond_pass, 0);
      inst_valid = 1; tick(); settle();
      check("itte_done", itstate, 8'h00);
      check("itte_done_we", it_we, 1);
      inst_valid = 1; tick(); settle();
      check("idle_adv_we", it_we, 0);

      // exception mid-block
      load(4'b0000, 4'b0110);
      inst_valid = 1; tick();
      exc_entry = 1; tick(); settle();
      check("exc_entry", itstate, 8'h00);
      check("exc_entry_we", it_we, 1);
      exc_return = 1; ret_it = 8'h0C; tick(); settle();
      check("exc_ret", itstate, 8'h0C);
      check("exc_ret_rem", it_rem, 2);

      // same-cycle conflicts
      exc_entry = 1; it_load = 1; it_firstcond = 4'b0000; it_mask = 4'b1000;
      tick(); settle();
      check("conf_exc_load", itstate, 8'h00);
      check("conf_exc_err", it_err, 0);
      msr_we = 1; msr_it = 8'h48; inst_valid = 1; tick(); settle();
      check("conf_msr_adv", itstate, 8'h48);
      msr_we = 1; msr_it = 8'h48; tick(); settle();
      check("msr_same_we", it_we, 0);

      // nested IT
      exc_entry = 1; tick();
      load(4'b0000, 4'b0110);
      settle();
      check("nest_first_err", it_err, 0);
      load(4'b1010, 4'b1000);
      settle();
      check("nest_load", itstate, 8'hA8);
      check("nest_err", it_err, 1);
      load(4'b0011, 4'b0000);
      settle();
      check("nest_nop", itstate, 8'hA8);
      check("nest_nop_we", it_we, 0);
      check("nest_nop_err", it_err, 0);

      // condition sweep
      for (int c = 0; c < 16; c++) begin
         exc_entry = 1; tick();
         load(c[3:0], 4'b1000);
         for (int f = 0; f < 16; f++) begin
            apsr_nzcv = f[3:0];
            settle();
         end
      end
      apsr_nzcv = 4'b0100; settle();
      check("sweep_ge_lit", cond_pass, 1);       // cond 1111 always passes
      apsr_nzcv = 4'b1000;
      msr_we = 1; msr_it = 8'hB8; tick(); settle();
      check("lt_n1v0", cond_pass, 1);
      apsr_nzcv = 4'b0110;
      msr_we = 1; msr_it = 8'h88; tick(); settle();
      check("hi_z1", cond_pass, 0);
      inst_valid = 1; tick(); settle();
      check("sweep_end", itstate, 8'h00);

      // reset mid-block
      msr_we = 1; msr_it = 8'h18; tick(); settle();
      check("pre_rst", itstate, 8'h18);
      rst = 1; tick(); settle();
      check("post_rst_its", itstate, 8'h00);
      check("post_rst_last", last_in_it, 0);
      check("post_rst_cp", cond_pass, 1);
      check("post_rst_we", it_we, 0);
      check("post_rst_err", it_err, 0);
      tick(); settle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/it_block_ctrl.md
IT_BLOCK_CTRL -- requirements
Module: it_block_ctrl

Interface
REQ-001 SHALL provide ports, one per line (name direction width meaning), clock and reset first:
  clk  in  1  clock; all state updates on rising edge.
  rst  in  1  synchronous, active-high reset.
  it_load  in  1  IT instruction retired this cycle.
  it_firstcond  in  4  IT firstcond field.
  it_mask  in  4  IT mask field.
  inst_valid  in  1  non-IT instruction retired this cycle.
  apsr_nzcv  in  4  current flags {N,Z,C,V}.
  exc_entry  in  1  exception entry; IT state is abandoned.
  exc_return  in  1  exception return; restore IT state.
  ret_it  in  8  stacked ITSTATE for restore.
  msr_we  in  1  direct EPSR IT-field write.
  msr_it  in  8  ITSTATE value for direct write.
  itstate  out  8  current ITSTATE[7:0].
  in_it  out  1  itstate[3:0] != 0.
  cond_pass  out  1  current instruction's IT condition passes.
  last_in_it  out  1  current instruction is the last of its block.
  it_rem  out  3  instructions left in the block, 0..4.
  it_we  out  1  one-cycle pulse; itstate changed on the preceding edge.
  it_err  out  1  one-cycle pulse; IT loaded while in_it was already 1.
REQ-002 SHALL use reset rst, synchronous, active-high, on clock clk.

Function
REQ-003 SHALL hold ITSTATE as {base_cond[7:5], cond_lsb_and_mask[4:0]}; the current condition is itstate[7:4].
REQ-004 SHALL apply at most one update per edge, in this priority: exc_entry > exc_return > msr_we > it_load > inst_valid.
REQ-005 exc_entry SHALL set itstate to 0x00.
REQ-006 exc_return SHALL set itstate to ret_it.
REQ-007 msr_we SHALL set itstate to msr_it.
REQ-008 it_load with it_mask != 0000 SHALL set itstate to {it_firstcond, it_mask}.
REQ-009 it_load with it_mask == 0000 SHALL leave itstate unchanged and assert neither it_we nor it_err.
REQ-010 it_load accepted while in_it==1 SHALL still load itstate and pulse it_err on the next cycle.
REQ-011 inst_valid with in_it==1 SHALL advance itstate: if itstate[2:0]==000, clear it to 0x00; otherwise keep itstate[7:5] and shift itstate[4:0] left by 1, with 0 entering the LSB.
REQ-012 inst_valid with in_it==0 SHALL leave itstate unchanged.
REQ-013 The FSM SHALL be derived from itstate: IDLE (itstate[3:0]==0000), LAST (itstate[3:0]==1000), ACTIVE (all other values).
REQ-014 Allowed transitions: IDLE->ACTIVE/LAST on load; ACTIVE->ACTIVE/LAST on advance; LAST->IDLE on advance; any state->IDLE on exc_entry; any state->any state on exc_return/msr_we.
REQ-015 it_rem SHALL be combinational from itstate[3:0]: 0000->0, 1000->1, x100->2, xx10->3, xxx1->4.
REQ-016 last_in_it SHALL equal (it_rem==1).
REQ-017 When in_it==0, cond_pass SHALL be 1.
REQ-018 When in_it==1, cond_pass SHALL follow the ARM encoding of itstate[7:4]: EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V; HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V); 1110 and 1111 always pass.
REQ-019 cond_pass SHALL be combinational from itstate and apsr_nzcv, so the flags seen are the same-cycle flags.
REQ-020 it_we SHALL pulse 1 cycle after any edge on which the itstate value changed; there SHALL be no pulse if the value written equals the old value.

Reset
REQ-021 rst SHALL take precedence over all inputs.
REQ-022 In the cycle after rst, itstate=0x00, in_it=0, cond_pass=1, last_in_it=0, it_rem=0, it_we=0, it_err=0.
REQ-023 rst asserted mid-block SHALL abandon the block with no it_we pulse.

Verification
REQ-024 ITTE EQ: it_load, firstcond=0000, mask=0110 -> itstate 0x06 (it_rem=3). Three inst_valid -> 0x0C (rem 2), 0x18 (cond NE, last_in_it=1), 0x00. With Z=1, cond_pass = 1,1,0.
REQ-025 Exception mid-block: at itstate 0x0C, pulse exc_entry -> itstate 0x00 and it_we pulse. Then exc_return with ret_it=0x0C -> itstate 0x0C, it_rem=2.
REQ-026 Same-cycle conflict: exc_entry and it_load (0000/1000) in one cycle -> itstate 0x00. msr_we (0x48) and inst_valid in one cycle -> itstate 0x48.
REQ-027 Nested IT: at itstate 0x06, it_load firstcond=1010, mask=1000 -> itstate 0xA8 and it_err pulse. it_load with mask=0000 -> no change, no pulses.
REQ-028 Condition sweep: for each cond 0000-1111 loaded with mask 1000, drive all 16 NZCV values -> cond_pass matches the table in REQ-018. Then one inst_valid -> itstate 0x00.
REQ-029 Reset: rst asserted at itstate 0x18 -> all outputs at their reset values next cycle, and no it_we pulse.
